// File: rtl/mem_bus_ctrl_if.sv
// Core/memory bus bundle for mem_bus_ctrl: core request/ack handshake,
// external memory strobes and a debug view of the controller FSM state.
interface mem_bus_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // Core side: req/we/addr/wdata are sampled only while the controller is idle;
  // ack (with err on timeout) is a one-cycle completion pulse, and rdata is
  // valid while ack=1 and held until the next completion.
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;
  logic [7:0]    err_cnt;
  // Memory side
  logic [AW-1:0] Abus;
  logic [DW-1:0] Dbusout;
  logic [DW-1:0] Dbusin;
  logic          memrd;
  logic          memwr;
  logic          mready;
  logic [1:0]    dbg_state;

  modport slave (
    input  req, we, addr, wdata, Dbusin, mready,
    output ack, err, rdata, err_cnt, Abus, Dbusout, memrd, memwr, dbg_state
  );

  modport master (
    output req, we, addr, wdata, Dbusin, mready,
    input  ack, err, rdata, err_cnt, Abus, Dbusout, memrd, memwr, dbg_state
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: request/ack handshake to the core, minimum wait states,
// mready-qualified completion and a bus timeout with a saturating error counter.
module mem_bus_ctrl #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MIN_WAIT = 0,
  parameter int TIMEOUT  = 15
) (
  input logic          clk,
  input logic          rst_n,
  mem_bus_ctrl_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  generate
    if (TIMEOUT <= MIN_WAIT) begin : g_bad_cfg
      $error("mem_bus_ctrl: TIMEOUT must be greater than MIN_WAIT");
    end
  endgenerate

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          we_q;
  logic [AW-1:0] abus_q;
  logic [DW-1:0] dbusout_q;
  logic [DW-1:0] rdata_q;
  logic [7:0]    err_cnt_q;
  logic          memrd_q;
  logic          memwr_q;
  logic          ack_q;
  logic          err_q;
  logic          wait_met;
  logic          timeout_hit;

  assign cnt_d = cnt_q + 1'b1;

  // With no minimum wait the comparison would be constant, so it is not built.
  generate
    if (MIN_WAIT == 0) begin : g_nowait
      assign wait_met = 1'b1;
    end else begin : g_wait
      assign wait_met = (cnt_q >= CW'(MIN_WAIT));
    end
  endgenerate

  assign timeout_hit = (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      abus_q    <= '0;
      dbusout_q <= '0;
      rdata_q   <= '0;
      err_cnt_q <= 8'd0;
      memrd_q   <= 1'b0;
      memwr_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (bus.req) begin
            we_q    <= bus.we;
            abus_q  <= bus.addr;
            memrd_q <= ~bus.we;
            memwr_q <= bus.we;
            if (bus.we) dbusout_q <= bus.wdata;
            cnt_q   <= '0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // Completion wins over timeout when both land on the same edge.
          if (wait_met && bus.mready) begin
            memrd_q <= 1'b0;
            memwr_q <= 1'b0;
            ack_q   <= 1'b1;
            if (!we_q) rdata_q <= bus.Dbusin;
            state_q <= DONE;
          end else if (timeout_hit) begin
            memrd_q <= 1'b0;
            memwr_q <= 1'b0;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            if (!we_q) rdata_q <= '1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            state_q <= ERR;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE, ERR: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.Abus      = abus_q;
  assign bus.Dbusout   = dbusout_q;
  assign bus.memrd     = memrd_q;
  assign bus.memwr     = memwr_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (MIN_WAIT=0 and MIN_WAIT=2) share the
// stimulus; expected {err, rdata} completions go through a scoreboard queue.
module tb_mem_bus_ctrl;
  localparam int W = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        mready = 1'b0;
  logic        echo = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] dbus = '0;

  logic [W-1:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] rd_model[2];
  int err_model = 0;

  mem_bus_ctrl_if #(.AW(16), .DW(16)) b0 ();
  mem_bus_ctrl_if #(.AW(16), .DW(16)) b2 ();

  assign b0.req    = req & ~sel;
  assign b2.req    = req & sel;
  assign b0.we     = we;
  assign b2.we     = we;
  assign b0.addr   = addr;
  assign b2.addr   = addr;
  assign b0.wdata  = wdata;
  assign b2.wdata  = wdata;
  assign b0.Dbusin = echo ? ~b0.Abus : dbus;
  assign b2.Dbusin = dbus;
  assign b0.mready = mready;
  assign b2.mready = mready;

  mem_bus_ctrl #(.AW(16), .DW(16), .MIN_WAIT(0), .TIMEOUT(15)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave));
  mem_bus_ctrl #(.AW(16), .DW(16), .MIN_WAIT(2), .TIMEOUT(15)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));

  logic        m_ack, m_err, m_memrd, m_memwr;
  logic [15:0] m_abus, m_dbusout, m_rdata;
  logic [7:0]  m_err_cnt;
  logic [1:0]  m_state;
  assign m_ack     = sel ? b2.ack : b0.ack;
  assign m_err     = sel ? b2.err : b0.err;
  assign m_memrd   = sel ? b2.memrd : b0.memrd;
  assign m_memwr   = sel ? b2.memwr : b0.memwr;
  assign m_abus    = sel ? b2.Abus : b0.Abus;
  assign m_dbusout = sel ? b2.Dbusout : b0.Dbusout;
  assign m_rdata   = sel ? b2.rdata : b0.rdata;
  assign m_err_cnt = sel ? b2.err_cnt : b0.err_cnt;
  assign m_state   = sel ? b2.dbg_state : b0.dbg_state;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the selected DUT; pat[i] is mready in ACCESS cycle i.
  task automatic access(input bit s, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input logic [31:0] pat, input bit tail,
                        input int exp_len, input bit exp_err, input string name);
    logic [W-1:0] e;
    logic [15:0]  exp_rd;
    int i;
    int strobes;
    int bad;
    sel = s; we = w; addr = a; wdata = d; mready = 1'b0; req = 1'b1;
    if (w) exp_rd = rd_model[s];
    else if (exp_err) exp_rd = 16'hFFFF;
    else exp_rd = dbus;
    rd_model[s] = exp_rd;
    exp_q.push_back({exp_err, exp_rd});
    if (exp_err && !s && err_model < 255) err_model++;
    tick();
    req = 1'b0;
    i = 0; strobes = 0; bad = 0;
    while (m_ack !== 1'b1 && i < 40) begin
      if (m_memrd || m_memwr) begin
        strobes++;
        if (m_abus !== a) bad++;
        if (w && (m_memwr !== 1'b1 || m_memrd !== 1'b0 || m_dbusout !== d)) bad++;
        if (!w && (m_memrd !== 1'b1 || m_memwr !== 1'b0)) bad++;
      end
      mready = (i < 32) ? pat[i] : tail;
      tick();
      i++;
    end
    total_cnt++;
    if (m_ack !== 1'b1) $display("FAIL %s ack_seen: got no ack, required ack within 40 cycles", name);
    else pass_cnt++;
    total_cnt++;
    if (i != exp_len) $display("FAIL %s latency: got %0d edges, required %0d", name, i, exp_len);
    else pass_cnt++;
    total_cnt++;
    if (strobes != exp_len) $display("FAIL %s strobe_width: got %0d, required %0d", name, strobes, exp_len);
    else pass_cnt++;
    total_cnt++;
    if (bad != 0) $display("FAIL %s strobe_bus: got %0d bad cycles, required 0", name, bad);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() == 0) $display("FAIL %s scoreboard: got empty queue, required an entry", name);
    else begin
      e = exp_q.pop_front();
      if ({m_err, m_rdata} !== e) $display("FAIL %s err_rdata: got %h, required %h", name, {m_err, m_rdata}, e);
      else pass_cnt++;
    end
    mready = 1'b0;
    tick();
    total_cnt++;
    if ({m_ack, m_err, m_memrd, m_memwr} !== 4'b0 || m_rdata !== exp_rd)
      $display("FAIL %s after_ack: got ack/err/rd/wr=%b rdata=%h, required 0000 rdata=%h",
               name, {m_ack, m_err, m_memrd, m_memwr}, m_rdata, exp_rd);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #0;
      total_cnt++;
      if ({m_ack, m_err, m_memrd, m_memwr, m_state} !== 6'b0)
        $display("FAIL reset_ctl[%0d]: got %b, required 000000", k, {m_ack, m_err, m_memrd, m_memwr, m_state});
      else pass_cnt++;
      total_cnt++;
      if ({m_abus, m_dbusout, m_rdata, m_err_cnt} !== 56'h0)
        $display("FAIL reset_data[%0d]: got %h, required 0", k, {m_abus, m_dbusout, m_rdata, m_err_cnt});
      else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    dbus = 16'h3333;
    access(1'b0, 1'b0, 16'h0300, 16'h0000, 32'h0, 1'b0, 16, 1'b1, "timeout");
    total_cnt++;
    if (m_err_cnt !== 8'd1) $display("FAIL timeout_cnt1: got %0d, required 1", m_err_cnt);
    else pass_cnt++;
    for (int k = 0; k < 259; k++)
      access(1'b0, 1'b0, 16'(k), 16'h0000, 32'h0, 1'b0, 16, 1'b1, "timeout_rep");
    total_cnt++;
    if (m_err_cnt !== 8'(err_model) || err_model != 255)
      $display("FAIL timeout_sat: got %0d, required 255 (model %0d)", m_err_cnt, err_model);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    sel = 1'b0; we = 1'b0; addr = 16'h0ABC; mready = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (m_memrd !== 1'b1) $display("FAIL rst_mid_pre: got memrd=%b, required 1", m_memrd);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({m_ack, m_err, m_memrd, m_memwr, m_state} !== 6'b0)
      $display("FAIL rst_mid_ctl: got %b, required 000000", {m_ack, m_err, m_memrd, m_memwr, m_state});
    else pass_cnt++;
    total_cnt++;
    if ({m_abus, m_dbusout, m_rdata, m_err_cnt} !== 56'h0)
      $display("FAIL rst_mid_data: got %h, required 0", {m_abus, m_dbusout, m_rdata, m_err_cnt});
    else pass_cnt++;
    rd_model[0] = '0; rd_model[1] = '0; err_model = 0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    total_cnt++;
    if (m_ack !== 1'b0) $display("FAIL rst_mid_noack: got ack=%b, required 0", m_ack);
    else pass_cnt++;
    dbus = 16'h4321;
    access(1'b0, 1'b0, 16'h0500, 16'h0000, 32'hFFFF_FFFF, 1'b1, 1, 1'b0, "post_reset");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    int ack_at[2];
    int n_ack;
    int i;
    sel = 1'b0; echo = 1'b1; mready = 1'b1; we = 1'b0; addr = 16'h0001; req = 1'b1;
    exp_q.push_back({1'b0, ~16'h0001});
    exp_q.push_back({1'b0, ~16'h0002});
    tick();
    addr = 16'h0002;
    n_ack = 0; i = 0; ack_at[0] = -1; ack_at[1] = -1;
    while (n_ack < 2 && i < 12) begin
      if (m_ack === 1'b1) begin
        ack_at[n_ack] = i;
        n_ack++;
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL b2b_scoreboard: got empty queue, required an entry");
        else begin
          e = exp_q.pop_front();
          if ({m_err, m_rdata} !== e) $display("FAIL b2b_rdata: got %h, required %h", {m_err, m_rdata}, e);
          else pass_cnt++;
        end
        if (n_ack == 2) req = 1'b0;
      end
      if (n_ack < 2) begin
        tick();
        i++;
      end
    end
    req = 1'b0;
    total_cnt++;
    if (n_ack != 2 || ack_at[0] != 1 || ack_at[1] - ack_at[0] != 3)
      $display("FAIL b2b_spacing: got %0d acks at %0d,%0d, required 2 acks at 1,4", n_ack, ack_at[0], ack_at[1]);
    else pass_cnt++;
    echo = 1'b0; mready = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({m_ack, m_memrd} !== 2'b00) $display("FAIL b2b_idle: got %b, required 00", {m_ack, m_memrd});
    else pass_cnt++;
  endtask

  initial begin
    rd_model[0] = '0;
    rd_model[1] = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    test_reset();
    // zero-wait read
    dbus = 16'hBEEF;
    access(1'b0, 1'b0, 16'h0040, 16'h0000, 32'hFFFF_FFFF, 1'b1, 1, 1'b0, "zero_wait_read");
    // write with two wait states
    access(1'b1, 1'b1, 16'h1234, 16'h5A5A, 32'hFFFF_FFFF, 1'b1, 3, 1'b0, "write_wait2");
    // late ready on MIN_WAIT=0
    dbus = 16'h1111;
    access(1'b0, 1'b0, 16'h0100, 16'h0000, 32'hFFFF_FFF0, 1'b1, 5, 1'b0, "late_ready");
    // early mready pulse ignored on MIN_WAIT=2
    dbus = 16'h2222;
    access(1'b1, 1'b0, 16'h0200, 16'h0000, 32'hFFFF_FFF2, 1'b1, 5, 1'b0, "ready_ignored");
    // write keeps previous rdata
    access(1'b1, 1'b1, 16'h0202, 16'hC3C3, 32'hFFFF_FFFF, 1'b1, 3, 1'b0, "write_keeps_rdata");
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
